regfile_sync: RTL

Parametrised, clocked register file for the MIPS datapath: two asynchronous read ports and one synchronous write port with internal rd/rt destination select. It adds a hardwired-zero option, write-to-read bypass, and a reset-clear sequencer that zeroes storage one entry per cycle. It sits between instruction decode and the ALU operand muxes.

---
 rtl/regfile_sync.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regfile_sync.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sync
//  Description : MIPS datapath register file. Two combinational read ports,
//                one synchronous write port with rd/rt destination select,
//                optional hardwired-zero entry 0, optional same-cycle
//                write-to-read bypass, and a reset-time clear sequencer that
//                zeroes one entry per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_sync #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int ZERO_REG       = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  regDest,
    input  logic                  regWrite,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt,
    input  logic [ADDR_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0] rsData,
    output logic [DATA_WIDTH-1:0] rtData,
    output logic                  busy
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    localparam logic [0:0] S_READY = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] c_last_idx = ADDR_WIDTH'(NUM_REGS - 1);

    logic [0:0]            r_state;
    logic [0:0]            w_next_state;
    logic [ADDR_WIDTH-1:0] r_clr_idx;
    logic                  w_busy;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [ADDR_WIDTH-1:0] w_write_addr;
    logic                  w_write_ok;

    // Destination register: rd for R-type, rt for I-type.
    assign w_write_addr = regDest ? rd : rt;

    // A write commits only in READY, outside reset, and never to a hardwired zero.
    assign w_write_ok = regWrite && !w_busy && !rst &&
                        !((ZERO_REG != 0) && (w_write_addr == '0));

    // State register and clear index; reset always restarts the clear from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_CLEAR) && (CLEAR_ON_RESET != 0)) begin
                r_clr_idx <= r_clr_idx + ADDR_WIDTH'(1);
            end
        end
    end

    // Next-state: leave CLEAR after the last entry is zeroed (or at once if not clearing).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_CLEAR: begin
                if (CLEAR_ON_RESET == 0) begin
                    w_next_state = S_READY;
                end else if (r_clr_idx == c_last_idx) begin
                    w_next_state = S_READY;
                end
            end
            default: w_next_state = S_READY;
        endcase
    end

    // Output decode: busy comes straight from the registered state.
    always_comb begin
        w_busy = (r_state == S_CLEAR);
    end

    assign busy = w_busy;

    // Storage update: clear sequencer has priority; normal writes only when allowed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((r_state == S_CLEAR) && (CLEAR_ON_RESET != 0)) begin
                r_regs[r_clr_idx] <= '0;
            end else if (w_write_ok) begin
                r_regs[w_write_addr] <= writeData;
            end
        end
    end

    // Read port A: busy and zero-reg force 0, then bypass, then storage.
    always_comb begin
        rsData = r_regs[rs];
        if (w_busy) begin
            rsData = '0;
        end else if ((ZERO_REG != 0) && (rs == '0)) begin
            rsData = '0;
        end else if ((BYPASS != 0) && w_write_ok && (rs == w_write_addr)) begin
            rsData = writeData;
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        rtData = r_regs[rt];
        if (w_busy) begin
            rtData = '0;
        end else if ((ZERO_REG != 0) && (rt == '0)) begin
            rtData = '0;
        end else if ((BYPASS != 0) && w_write_ok && (rt == w_write_addr)) begin
            rtData = writeData;
        end
    end

endmodule
`default_nettype wire
